// File: rtl/npc_pkg.sv
// Shared types for the fetch/load-store memory arbiter.
// Holds the FSM state encoding, owner encoding and default bus widths.
package npc_pkg;
    localparam int NPC_ADDR_W = 64;
    localparam int NPC_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: under contention the requester that did not win last time wins.
// Purely combinational, no latency; no backpressure of its own.
module rr_arb2 import npc_pkg::*; (
    input  logic   req0,
    input  logic   req1,
    input  owner_e last,
    output owner_e grant
);
    always_comb begin
        grant = OWN_IFU;
        if (req0 && req1) begin
            grant = (last == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end else if (req1) begin
            grant = OWN_LSU;
        end
    end
endmodule

// File: rtl/imem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Latency: accept at N, memory request from N+1, response passed through combinationally.
// Backpressure: requesters see ready only in IDLE; mem_req_valid and mem_* hold until mem_req_ready.
module imem_arbiter import npc_pkg::*; #(
    parameter int ADDR_W = NPC_ADDR_W,
    parameter int DATA_W = NPC_DATA_W,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    input  logic              ifu_flush,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [STRB_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wmask;
    } mem_req_t;

    state_e   state;
    owner_e   owner;
    owner_e   last_owner;
    owner_e   grant;
    logic     drop;
    mem_req_t req_q;
    mem_req_t req_d;
    logic     idle;
    logic     ifu_acc;
    logic     lsu_acc;
    logic     flush_hit;

    rr_arb2 u_rr_arb2 (
        .req0  (ifu_req_valid),
        .req1  (lsu_req_valid),
        .last  (last_owner),
        .grant (grant)
    );

    // Readiness is masked during reset so nothing is accepted in a reset cycle.
    assign idle          = (state == IDLE) && !rst;
    assign ifu_req_ready = idle && (grant == OWN_IFU) && !ifu_flush;
    assign lsu_req_ready = idle && (grant == OWN_LSU);
    assign ifu_acc       = ifu_req_valid && ifu_req_ready;
    assign lsu_acc       = lsu_req_valid && lsu_req_ready;
    assign flush_hit     = ifu_flush && (owner == OWN_IFU);

    always_comb begin
        req_d = '{addr: ifu_addr, wen: 1'b0, wdata: '0, wmask: '0};
        if (lsu_acc) begin
            req_d = '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_IFU;
            last_owner    <= OWN_IFU;
            drop          <= 1'b0;
            mem_req_valid <= 1'b0;
            req_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ifu_acc || lsu_acc) begin
                        req_q         <= req_d;
                        owner         <= lsu_acc ? OWN_LSU : OWN_IFU;
                        last_owner    <= lsu_acc ? OWN_LSU : OWN_IFU;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (flush_hit) begin
                        drop <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        drop  <= 1'b0;
                        state <= IDLE;
                    end else if (flush_hit) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr  = req_q.addr;
    assign mem_wen   = req_q.wen;
    assign mem_wdata = req_q.wdata;
    assign mem_wmask = req_q.wmask;

    // A flush in the response cycle itself also swallows the fetch data.
    assign ifu_resp_valid = !rst && mem_resp_valid && (state == WAIT) && (owner == OWN_IFU)
                            && !drop && !ifu_flush;
    assign lsu_resp_valid = !rst && mem_resp_valid && (state == WAIT) && (owner == OWN_LSU);
    assign ifu_rdata      = mem_rdata;
    assign lsu_rdata      = req_q.wen ? '0 : mem_rdata;

    mem_resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        mem_resp_valid |-> (state == WAIT));
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: memory model, scoreboard queues and a response monitor.
module tb_imem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_flush, ifu_resp_valid;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    always #5 clk = ~clk;

    imem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_flush      (ifu_flush),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [63:0] exp_ifu[$];
    logic [63:0] exp_lsu[$];
    int          glog[$];
    int          gcyc[$];
    int          m_lat = 0;
    int          m_stall = 0;
    logic        hs_s = 1'b0;
    logic        rst_s = 1'b0;
    logic [63:0] addr_s = '0;
    logic        wen_s = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        case (a)
            64'h0000_0000_8000_0000: return 64'h0000_0000_0000_0413;
            64'h0000_0000_8000_0040: return 64'h0000_0000_0000_8067;
            64'h0000_0000_8000_2000: return 64'h1122_3344_5566_7788;
            default:                 return 64'hEEEE_EEEE_EEEE_EEEE;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle-stable snapshots taken mid-cycle for the memory model.
    always @(negedge clk) begin
        hs_s   <= mem_req_valid && mem_req_ready;
        rst_s  <= rst;
        addr_s <= mem_addr;
        wen_s  <= mem_wen;
    end

    // Memory model: m_stall cycles of ready-low, then response m_lat cycles after the handshake.
    initial begin
        int          stall_cnt;
        int          cnt;
        logic        busy;
        logic [63:0] raddr;
        logic        rwen;
        stall_cnt = 0; cnt = 0; busy = 1'b0; raddr = '0; rwen = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            mem_rdata      = '0;
            if (rst_s) begin
                busy = 1'b0; stall_cnt = 0; mem_req_ready = 1'b0;
            end else begin
                if (hs_s) begin
                    busy = 1'b1; cnt = m_lat; raddr = addr_s; rwen = wen_s; stall_cnt = 0;
                end
                if (busy) begin
                    if (cnt == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_rdata      = rwen ? 64'hBAD0_BAD0_BAD0_BAD0 : mem_read(raddr);
                        busy           = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (mem_req_valid && stall_cnt < m_stall) begin
                    mem_req_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    mem_req_ready = mem_req_valid;
                end
            end
        end
    end

    // Response monitor: every response must match the head of its expectation queue.
    always @(negedge clk) begin
        if (ifu_resp_valid) begin
            chk("ifu_resp_expected", 64'(exp_ifu.size() != 0), 64'd1);
            if (exp_ifu.size() != 0) chk("ifu_rdata", ifu_rdata, exp_ifu.pop_front());
        end
        if (lsu_resp_valid) begin
            chk("lsu_resp_expected", 64'(exp_lsu.size() != 0), 64'd1);
            if (exp_lsu.size() != 0) chk("lsu_rdata", lsu_rdata, exp_lsu.pop_front());
        end
        if (ifu_req_valid && ifu_req_ready) begin glog.push_back(0); gcyc.push_back(cyc); end
        if (lsu_req_valid && lsu_req_ready) begin glog.push_back(1); gcyc.push_back(cyc); end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_ifu.size() == 0 && exp_lsu.size() == 0) break;
            @(posedge clk);
        end
        chk(name, 64'(exp_ifu.size() + exp_lsu.size()), 64'd0);
    endtask

    initial begin
        logic [3:0] g;
        rst = 1'b1; ifu_flush = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_2000; lsu_wen = 1'b0;
        lsu_wdata = '0; lsu_wmask = '0;
        exp_lsu.push_back(64'h1122_3344_5566_7788);
        exp_ifu.push_back(64'h0000_0000_0000_0413);
        exp_lsu.push_back(64'h1122_3344_5566_7788);
        exp_ifu.push_back(64'h0000_0000_0000_0413);

        // Reset held for two edges with both requesters valid.
        @(posedge clk); @(negedge clk);
        chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 64'd0);
        chk("rst_valid", {mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        chk("rst_mem_regs", {mem_wen, |mem_addr, |mem_wdata, |mem_wmask}, 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("first_grant_lsu", {ifu_req_ready, lsu_req_ready}, 64'b01);

        // Contention: alternate grants starting with LSU, one every 3 cycles.
        for (int i = 0; i < 60; i++) begin
            if (glog.size() >= 4) break;
            @(posedge clk);
        end
        #1; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        chk("grant_count", 64'(glog.size()), 64'd4);
        if (glog.size() >= 4) begin
            g = {glog[0] == 1, glog[1] == 1, glog[2] == 1, glog[3] == 1};
            chk("grant_order", 64'(g), 64'b1010);
            chk("grant_spacing", 64'(gcyc[3] - gcyc[0]), 64'd9);
        end
        drain("contention_drain");

        // Single fetch with zero-wait memory: accept N, mem_req N+1, resp N+2.
        exp_ifu.push_back(64'h0000_0000_0000_0413);
        step(); ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
        @(negedge clk); chk("fetch_accept", 64'(ifu_req_ready), 64'd1);
        step(); ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("fetch_mem_req", {mem_req_valid, mem_wen, mem_wmask}, {54'd0, 1'b1, 1'b0, 8'h00});
        chk("fetch_mem_addr", mem_addr, 64'h8000_0000);
        @(negedge clk); chk("fetch_resp_n2", 64'(ifu_resp_valid), 64'd1);
        drain("fetch_drain");

        // Store with three stall cycles: request held stable, response data zero.
        m_stall = 3;
        exp_lsu.push_back(64'd0);
        step(); lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_1000;
        lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
        @(negedge clk); chk("store_accept", 64'(lsu_req_ready), 64'd1);
        step(); lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("store_hold", {mem_req_valid, mem_wen, mem_addr == 64'h8000_1000,
                               mem_wdata == 64'hDEAD_BEEF, mem_wmask == 8'h0F}, 64'h1F);
        end
        @(negedge clk); chk("store_resp", {mem_req_valid, lsu_resp_valid}, 64'b01);
        drain("store_drain");
        m_stall = 0;

        // Flush during a slow fetch: the stale response is swallowed, redirect follows.
        m_lat = 5;
        exp_ifu.push_back(64'h0000_0000_0000_8067);
        step(); ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
        @(negedge clk); chk("flush_fetch_accept", 64'(ifu_req_ready), 64'd1);
        step(); ifu_req_valid = 1'b0;
        step();
        step(); ifu_flush = 1'b1; ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0040;
        @(negedge clk); chk("flush_blocks_ready", 64'(ifu_req_ready), 64'd0);
        step(); ifu_flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_resp_valid) break;
        end
        chk("flush_mem_resp_seen", 64'(mem_resp_valid), 64'd1);
        chk("flush_resp_swallowed", 64'(ifu_resp_valid), 64'd0);
        step();
        @(negedge clk); chk("redirect_accept", 64'(ifu_req_ready && ifu_req_valid), 64'd1);
        chk("redirect_addr", ifu_addr, 64'h8000_0040);
        step(); ifu_req_valid = 1'b0;
        drain("flush_drain");

        // Reset while waiting on memory: transaction abandoned, then a clean fetch.
        step(); ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
        @(negedge clk); chk("mr_accept", 64'(ifu_req_ready), 64'd1);
        step(); ifu_req_valid = 1'b0;
        step();
        step(); rst = 1'b1;
        @(negedge clk); chk("mr_quiet_in_rst", {ifu_resp_valid, ifu_req_ready}, 64'd0);
        step(); rst = 1'b0;
        @(negedge clk); chk("mr_idle_after", {mem_req_valid, ifu_req_ready}, 64'b01);
        repeat (10) @(posedge clk);
        m_lat = 0;
        exp_ifu.push_back(64'h0000_0000_0000_0413);
        step(); ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
        @(negedge clk); chk("mr_refetch_accept", 64'(ifu_req_ready), 64'd1);
        step(); ifu_req_valid = 1'b0;
        drain("mr_drain");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
